// File: rtl/riscv_dmem_pkg.sv
// Shared types and widths for the RISC-V data-memory responder.
// The macro RISCV_DMEM_ERR_EN enables address error responses in riscv_dmem_responder.
package riscv_dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/riscv_dmem_array.sv
// Word storage for the data-memory responder: byte-strobed synchronous write, synchronous read.
// One commit pulse either writes the strobed lanes or captures the addressed word.
module riscv_dmem_array
    import riscv_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              commit,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata
);

    // Contents are never reset; they start at zero and persist across a_rst.
    logic [DATA_W-1:0] mem [DEPTH_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (commit) begin
            if (we) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb[b]) begin
                        mem[index][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Single-outstanding data-memory responder with WAIT_CYCLES wait states (IDLE/WAIT/RESP).
// Define RISCV_DMEM_ERR_EN to report misaligned or out-of-range addresses as errors.
module riscv_dmem_responder
    import riscv_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state;
    state_t            next_state;
    logic [3:0]        count;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [STRB_W-1:0] lat_wstrb;
    logic              err_q;

    logic              accept;
    logic              enter_resp;
    logic              addr_err;
    logic              commit;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [STRB_W-1:0] cur_wstrb;
    logic [DATA_W-1:0] arr_rdata;

    assign accept = (state == IDLE) && req_valid;

    // With zero wait states the array is hit on the accepting edge, before anything is latched.
    assign cur_we    = (state == IDLE) ? req_we    : lat_we;
    assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_wstrb = (state == IDLE) ? req_wstrb : lat_wstrb;

    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (count == 4'd0));

`ifdef RISCV_DMEM_ERR_EN
    assign addr_err = (cur_addr[1:0] != 2'b00) || (cur_addr >= ADDR_W'(4 * DEPTH_WORDS));
`else
    logic unused_addr_bits;
    assign addr_err         = 1'b0;
    assign unused_addr_bits = ^{cur_addr[1:0], cur_addr[ADDR_W-1:IDX_W+2]};
`endif

    assign commit = enter_resp && !addr_err;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (count == 4'd0) next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            count     <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
                count     <= 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
            end else if ((state == WAIT) && (count != 4'd0)) begin
                count <= count - 4'd1;
            end
            if (enter_resp) begin
                err_q <= addr_err;
            end
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !lat_we && !err_q) ? arr_rdata : '0;
    end

    riscv_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .commit(commit),
        .we    (cur_we),
        .index (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .wstrb (cur_wstrb),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: three instances (1, 0 and 3 wait states) against a word-array model.
// Expected error behaviour follows RISCV_DMEM_ERR_EN when it is defined for the build.
module tb_riscv_dmem_responder;

    localparam int N     = 3;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        a_rst      [N];
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic [31:0] req_addr   [N];
    logic        req_we     [N];
    logic [31:0] req_wdata  [N];
    logic [3:0]  req_wstrb  [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_rdata [N];
    logic        resp_err   [N];

    logic [31:0] model [N][DEPTH];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic int wait_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        riscv_dmem_responder #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) dut (
            .clk       (clk),
            .a_rst     (a_rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .req_we    (req_we[g]),
            .req_wdata (req_wdata[g]),
            .req_wstrb (req_wstrb[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    function automatic bit model_err(logic [31:0] a);
`ifdef RISCV_DMEM_ERR_EN
        return (a % 4 != 0) || (a >= 4 * DEPTH);
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic int model_idx(logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: request, latency, response, optional backpressure, handshake back to idle.
    task automatic apply_stimulus(int d, bit we, logic [31:0] addr, logic [31:0] wdata,
                                  logic [3:0] strb, int hold);
        logic [31:0] exp_rdata;
        logic [31:0] held_rdata;
        bit          exp_err;
        int          cycles;
        int          idx;
        exp_err   = model_err(addr);
        idx       = model_idx(addr);
        exp_rdata = (we || exp_err) ? 32'h0 : model[d][idx];
        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        @(negedge clk);
        check_output("req_ready_idle", 32'(req_ready[d]), 32'h1);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        req_wstrb[d]  = strb;
        resp_ready[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_wstrb[d] = 4'($urandom);
        cycles = 1;
        while (resp_valid[d] !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check_output("latency", 32'(cycles), 32'(wait_of(d) + 1));
        check_output("rdata", resp_rdata[d], exp_rdata);
        check_output("err", 32'(resp_err[d]), 32'(exp_err));
        held_rdata = resp_rdata[d];
        if (hold > 0) begin
            req_valid[d] = 1'b1;
            req_we[d]    = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_output("hold_valid", 32'(resp_valid[d]), 32'h1);
            check_output("hold_rdata", resp_rdata[d], held_rdata);
            check_output("hold_err", 32'(resp_err[d]), 32'(exp_err));
            check_output("hold_req_ready", 32'(req_ready[d]), 32'h0);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[d] = 1'b0;
        req_valid[d]  = 1'b0;
        check_output("done_valid", 32'(resp_valid[d]), 32'h0);
        check_output("done_req_ready", 32'(req_ready[d]), 32'h1);
    endtask

    initial begin
        int cycles;
        logic [31:0] a;
        for (int d = 0; d < N; d++) begin
            a_rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_wstrb[d] = '0; resp_ready[d] = 1'b0;
            for (int w = 0; w < DEPTH; w++) model[d][w] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check_output("rst_valid", 32'(resp_valid[d]), 32'h0);
            check_output("rst_rdata", resp_rdata[d], 32'h0);
            check_output("rst_err", 32'(resp_err[d]), 32'h0);
            a_rst[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) check_output("rst_req_ready", 32'(req_ready[d]), 32'h1);

        // Write/read, byte merge and backpressure on the one-wait-state instance.
        apply_stimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        apply_stimulus(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 0);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
        apply_stimulus(0, 1'b1, 32'h14, 32'h11112222, 4'h0, 0);
        apply_stimulus(0, 1'b0, 32'h14, 32'h0, 4'h0, 0);
        apply_stimulus(0, 1'b0, 32'h13, 32'h0, 4'h0, 0);
        apply_stimulus(0, 1'b0, 32'h400, 32'h0, 4'h0, 0);

        // Zero wait states.
        apply_stimulus(1, 1'b1, 32'h8, 32'hA5A5_5A5A, 4'hF, 0);
        apply_stimulus(1, 1'b0, 32'h8, 32'h0, 4'h0, 2);

        // Reset during WAIT discards the pending write.
        apply_stimulus(2, 1'b1, 32'h40, 32'h12345678, 4'hF, 0);
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h40;
        req_wdata[2] = 32'hCAFEF00D; req_wstrb[2] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        #1 a_rst[2] = 1'b1;
        #1;
        check_output("midrst_valid", 32'(resp_valid[2]), 32'h0);
        check_output("midrst_rdata", resp_rdata[2], 32'h0);
        check_output("midrst_err", 32'(resp_err[2]), 32'h0);
        @(negedge clk);
        a_rst[2] = 1'b0;
        check_output("midrst_req_ready", 32'(req_ready[2]), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("midrst_quiet", 32'(resp_valid[2]), 32'h0);
        end
        apply_stimulus(2, 1'b0, 32'h40, 32'h0, 4'h0, 0);

        // Reset while a read response is being held clears the outputs at once.
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h40;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        cycles = 1;
        while (resp_valid[2] !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check_output("resprst_rdata_before", resp_rdata[2], 32'h12345678);
        #1 a_rst[2] = 1'b1;
        #1;
        check_output("resprst_valid", 32'(resp_valid[2]), 32'h0);
        check_output("resprst_rdata", resp_rdata[2], 32'h0);
        @(negedge clk);
        a_rst[2] = 1'b0;
        check_output("resprst_req_ready", 32'(req_ready[2]), 32'h1);

        // Randomized traffic on every instance, mostly to a small window so reads hit prior writes.
        for (int d = 0; d < N; d++) begin
            for (int t = 0; t < 30; t++) begin
                case ($urandom_range(0, 9))
                    0:       a = 32'h400 + ($urandom_range(0, 63) * 4);
                    1:       a = ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
                    default: a = $urandom_range(0, 63) * 4;
                endcase
                apply_stimulus(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
